// File: rtl/mvm_pkg.sv
// Shared definitions for the sequential matrix-vector multiply engine:
// FSM state encoding, command codes and all datapath widths/dimensions.
package mvm_pkg;

  // Datapath widths
  localparam int ELEM_W = 4;           // signed matrix entry
  localparam int VEC_W  = 2;           // unsigned vector element
  localparam int RES_W  = 8;           // signed accumulator / result
  localparam int DIM    = 4;           // square matrix dimension

  // Derived sizes
  localparam int IN_W   = 2 * ELEM_W;  // one input byte carries two entries
  localparam int IDX_W  = $clog2(DIM);
  localparam int SLOTS  = (DIM * DIM) / 2;
  localparam int PTR_W  = $clog2(SLOTS);
  localparam int STEP_W = $clog2(DIM * DIM);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DIM * DIM - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIM - 1);

  // in_cmd encodings
  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_CLRPT = 2'b10;
  localparam logic [1:0] CMD_NOP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

endpackage

// File: rtl/mvm_mac.sv
// Single multiply-accumulate step: sum_o = acc_i + sext(m_i) * zext(v_i).
// Ports:
//   acc_i  signed running sum
//   m_i    signed matrix entry
//   v_i    unsigned vector element
//   sum_o  signed updated sum (wraps; operand ranges keep it in -96..84)
module mvm_mac
  import mvm_pkg::*;
(
  input  logic signed [RES_W-1:0]  acc_i,
  input  logic        [ELEM_W-1:0] m_i,
  input  logic        [VEC_W-1:0]  v_i,
  output logic signed [RES_W-1:0]  sum_o
);

  logic signed [RES_W-1:0] m_ext;
  logic signed [RES_W-1:0] v_ext;
  logic signed [RES_W-1:0] prod;

  // Both operands widened to the result width so the product is formed
  // as a signed multiply; v is zero-extended, hence never negative.
  assign m_ext = {{(RES_W-ELEM_W){m_i[ELEM_W-1]}}, m_i};
  assign v_ext = {{(RES_W-VEC_W){1'b0}}, v_i};
  assign prod  = m_ext * v_ext;
  assign sum_o = acc_i + prod;

endmodule

// File: rtl/mvm_seq_engine.sv
// Sequential 4x4 (signed 4-bit) by 4-vector (unsigned 2-bit) multiplier.
// The matrix is loaded two entries per byte, a start command latches the
// vector and runs 16 MAC steps (one per cycle), then the four row results
// are presented one at a time over a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 global enable; low freezes everything
//   in_data/in_cmd      command payload / opcode (write, start, clear ptr)
//   in_valid/in_ready   command handshake (ready only in IDLE)
//   out_data/out_idx    current row result and its row index
//   out_valid/out_ready result handshake
//   busy                high while computing or presenting results
module mvm_seq_engine
  import mvm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_cmd,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [RES_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_e                   state_q;
  logic [PTR_W-1:0]         wptr_q;
  logic signed [RES_W-1:0]  acc_q;
  logic signed [RES_W-1:0]  acc_d;
  logic [STEP_W-1:0]        step_q;
  logic [IDX_W-1:0]         oidx_q;
  logic [ELEM_W-1:0]        mat_q [DIM][DIM];
  logic signed [RES_W-1:0]  res_q [DIM];
  logic [VEC_W-1:0]         vec_q [DIM];

  logic [IDX_W-1:0]         row;
  logic [IDX_W-1:0]         col;
  logic [IDX_W-1:0]         wr_row;
  logic [IDX_W-1:0]         wr_col;

  // step = row*DIM + col, so the two index fields are just bit slices
  assign row = step_q[STEP_W-1 -: IDX_W];
  assign col = step_q[IDX_W-1:0];

  // byte slot k fills row k/2, columns 2*(k%2) and 2*(k%2)+1
  assign wr_row = wptr_q[PTR_W-1:1];
  assign wr_col = {wptr_q[0], 1'b0};

  mvm_mac u_mac (
    .acc_i (acc_q),
    .m_i   (mat_q[row][col]),
    .v_i   (vec_q[col]),
    .sum_o (acc_d)
  );

  assign in_ready  = (state_q == ST_IDLE) && ena;
  assign out_valid = (state_q == ST_OUTPUT) && ena;
  assign busy      = (state_q != ST_IDLE);
  assign out_idx   = oidx_q;
  assign out_data  = res_q[oidx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      oidx_q  <= '0;
      for (int r = 0; r < DIM; r++) begin
        res_q[r] <= '0;
        vec_q[r] <= '0;
        for (int c = 0; c < DIM; c++) begin
          mat_q[r][c] <= '0;
        end
      end
    end else if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            case (in_cmd)
              CMD_WRITE: begin
                mat_q[wr_row][wr_col]         <= in_data[ELEM_W-1:0];
                mat_q[wr_row][wr_col | 2'b01] <= in_data[IN_W-1:ELEM_W];
                wptr_q                        <= wptr_q + PTR_W'(1);
              end
              CMD_CLRPT: wptr_q <= '0;
              CMD_START: begin
                for (int i = 0; i < DIM; i++) begin
                  vec_q[i] <= in_data[VEC_W*i +: VEC_W];
                end
                acc_q   <= '0;
                step_q  <= '0;
                state_q <= ST_COMPUTE;
              end
              default: ;
            endcase
          end
        end

        ST_COMPUTE: begin
          // Last column of a row: commit the row sum and restart the sum
          if (col == IDX_LAST) begin
            res_q[row] <= acc_d;
            acc_q      <= '0;
          end else begin
            acc_q <= acc_d;
          end
          step_q <= step_q + STEP_W'(1);
          if (step_q == STEP_LAST) begin
            oidx_q  <= '0;
            state_q <= ST_OUTPUT;
          end
        end

        ST_OUTPUT: begin
          if (out_ready) begin
            oidx_q <= oidx_q + IDX_W'(1);
            if (oidx_q == IDX_LAST) begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_seq_engine.sv
module tb_mvm_seq_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] in_data;
  logic [1:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [1:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  always #5 clk = ~clk;

  mvm_seq_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_data   (in_data),
    .in_cmd    (in_cmd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int   mm [4][4];
  int   mwptr;

  // results captured by collect()
  int         c_lat;
  bit         c_timeout;
  int         c_stall_bad;
  int         c_gate_bad;
  logic [7:0] c_data [4];
  logic [1:0] c_idx  [4];

  initial begin
    #300000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mm[r][c] = 0;
    mwptr = 0;
  endtask

  task automatic model_write(input logic [7:0] b);
    logic signed [3:0] lo, hi;
    int r, c;
    lo = b[3:0];
    hi = b[7:4];
    r  = mwptr / 2;
    c  = 2 * (mwptr % 2);
    mm[r][c]     = lo;
    mm[r][c + 1] = hi;
    mwptr = (mwptr + 1) % 8;
  endtask

  task automatic push_expected(input logic [7:0] v);
    exp_t e;
    int   s;
    logic [1:0] ve;
    for (int r = 0; r < 4; r++) begin
      s = 0;
      for (int c = 0; c < 4; c++) begin
        ve = v[2*c +: 2];
        s += mm[r][c] * int'(ve);
      end
      e.idx  = 2'(r);
      e.data = 8'(s);
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] d);
    int n = 0;
    in_cmd   = cmd;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_ready got in_ready=%0b need 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_cmd   = 2'b11;
  endtask

  task automatic wr(input logic [7:0] b);
    send(2'b00, b);
    model_write(b);
  endtask

  task automatic start(input logic [7:0] v);
    push_expected(v);
    send(2'b01, v);
  endtask

  // Called right after a start is accepted; records latency and the four
  // transfers. Optionally drops ena mid-compute and/or stalls one output.
  task automatic collect(input int ena_at, input int ena_len,
                         input int stall_k, input int stall_len);
    int n = 0;
    int m;
    logic [7:0] d0;
    logic [1:0] i0;
    c_timeout = 0; c_stall_bad = 0; c_gate_bad = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 200) begin
      if (n == ena_at) begin
        ena = 1'b0;
        repeat (ena_len) begin
          tick();
          n++;
          if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) c_gate_bad++;
        end
        ena = 1'b1;
      end else begin
        tick();
        n++;
      end
    end
    c_lat = n + 1;
    if (!out_valid) c_timeout = 1;
    for (int k = 0; k < 4; k++) begin
      m = 0;
      while (!out_valid && m < 50) begin
        tick();
        m++;
      end
      if (!out_valid) c_timeout = 1;
      if (k == stall_k) begin
        out_ready = 1'b0;
        d0 = out_data;
        i0 = out_idx;
        in_valid = 1'b1; in_cmd = 2'b00; in_data = 8'hFF;
        repeat (stall_len) begin
          tick();
          if (out_data !== d0 || out_idx !== i0 || out_valid !== 1'b1 || in_ready !== 1'b0)
            c_stall_bad++;
        end
        in_valid = 1'b0; in_cmd = 2'b11;
        out_ready = 1'b1;
      end
      c_data[k] = out_data;
      c_idx[k]  = out_idx;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_cmd = 2'b11;
    in_data = 8'h00; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b need 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b need 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b need 0", busy); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %02h need 00", out_data); end
    checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL reset_out_idx got %0d need 0", out_idx); end
  endtask

  task automatic test_identity();
    exp_t e;
    logic [7:0] bytes [8] = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10};
    foreach (bytes[i]) wr(bytes[i]);
    start(8'h1B);
    collect(-1, 0, -1, 0);
    checks++; if (c_timeout) begin errors++; $display("FAIL ident_timeout got no output need 4 transfers"); end
    checks++; if (c_lat !== 17) begin errors++; $display("FAIL ident_latency got %0d need 17", c_lat); end
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front();
      checks++; if (c_data[k] !== e.data) begin errors++; $display("FAIL ident_data[%0d] got %02h need %02h", k, c_data[k], e.data); end
      checks++; if (c_idx[k] !== e.idx) begin errors++; $display("FAIL ident_idx[%0d] got %0d need %0d", k, c_idx[k], e.idx); end
    end
    // constant cross-check of the stated identity result
    checks++; if (c_data[0] !== 8'h03 || c_data[3] !== 8'h00) begin errors++; $display("FAIL ident_const got %02h,%02h need 03,00", c_data[0], c_data[3]); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ident_idle got ready=%0b busy=%0b need 1,0", in_ready, busy); end
  endtask

  task automatic test_extremes();
    exp_t e;
    logic [7:0] pat [2] = '{8'h88, 8'h77};
    logic [7:0] want [2] = '{8'hA0, 8'h54};
    for (int p = 0; p < 2; p++) begin
      repeat (8) wr(pat[p]);
      start(8'hFF);
      collect(-1, 0, -1, 0);
      checks++; if (c_timeout) begin errors++; $display("FAIL ext%0d_timeout got no output need 4 transfers", p); end
      for (int k = 0; k < 4; k++) begin
        e = sb.pop_front();
        checks++; if (c_data[k] !== e.data || c_data[k] !== want[p]) begin errors++; $display("FAIL ext%0d_data[%0d] got %02h need %02h", p, k, c_data[k], want[p]); end
        checks++; if (c_idx[k] !== e.idx) begin errors++; $display("FAIL ext%0d_idx[%0d] got %0d need %0d", p, k, c_idx[k], e.idx); end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [7:0] bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    foreach (bytes[i]) wr(bytes[i]);
    for (int run = 0; run < 2; run++) begin
      start(8'h6C);
      if (run == 0) collect(-1, 0, 1, 5);
      else collect(-1, 0, -1, 0);
      checks++; if (c_timeout) begin errors++; $display("FAIL bp%0d_timeout got no output need 4 transfers", run); end
      checks++; if (c_stall_bad != 0) begin errors++; $display("FAIL bp%0d_stable got %0d unstable cycles need 0", run, c_stall_bad); end
      for (int k = 0; k < 4; k++) begin
        e = sb.pop_front();
        checks++; if (c_data[k] !== e.data) begin errors++; $display("FAIL bp%0d_data[%0d] got %02h need %02h", run, k, c_data[k], e.data); end
        checks++; if (c_idx[k] !== e.idx) begin errors++; $display("FAIL bp%0d_idx[%0d] got %0d need %0d", run, k, c_idx[k], e.idx); end
      end
    end
  endtask

  task automatic test_pointer();
    exp_t e;
    logic [7:0] bytes [9] = '{8'h3A, 8'hC5, 8'h7E, 8'h81, 8'h2F, 8'hD6, 8'h49, 8'hB3, 8'h9E};
    foreach (bytes[i]) wr(bytes[i]);
    send(2'b10, 8'h00);
    mwptr = 0;
    wr(8'h6D);
    start(8'hE4);
    collect(-1, 0, -1, 0);
    checks++; if (c_timeout) begin errors++; $display("FAIL ptr_timeout got no output need 4 transfers"); end
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front();
      checks++; if (c_data[k] !== e.data) begin errors++; $display("FAIL ptr_data[%0d] got %02h need %02h", k, c_data[k], e.data); end
      checks++; if (c_idx[k] !== e.idx) begin errors++; $display("FAIL ptr_idx[%0d] got %0d need %0d", k, c_idx[k], e.idx); end
    end
  endtask

  task automatic test_ena_pause();
    exp_t e;
    start(8'hB1);
    collect(5, 10, -1, 0);
    checks++; if (c_timeout) begin errors++; $display("FAIL ena_timeout got no output need 4 transfers"); end
    checks++; if (c_lat !== 27) begin errors++; $display("FAIL ena_latency got %0d need 27", c_lat); end
    checks++; if (c_gate_bad != 0) begin errors++; $display("FAIL ena_gating got %0d bad cycles need 0", c_gate_bad); end
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front();
      checks++; if (c_data[k] !== e.data) begin errors++; $display("FAIL ena_data[%0d] got %02h need %02h", k, c_data[k], e.data); end
      checks++; if (c_idx[k] !== e.idx) begin errors++; $display("FAIL ena_idx[%0d] got %0d need %0d", k, c_idx[k], e.idx); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int vcount = 0;
    send(2'b01, 8'hFF);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %0b need 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b need 0", busy); end
    checks++; if (out_data !== 8'h00 || out_idx !== 2'd0) begin errors++; $display("FAIL rmid_outputs got %02h/%0d need 00/0", out_data, out_idx); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      tick();
      if (out_valid) vcount++;
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL rmid_no_valid got %0d valid cycles need 0", vcount); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %0b need 1", in_ready); end
    // matrix must have been cleared: everything computes to zero
    start(8'hFF);
    collect(-1, 0, -1, 0);
    checks++; if (c_timeout) begin errors++; $display("FAIL rmid_timeout got no output need 4 transfers"); end
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front();
      checks++; if (c_data[k] !== e.data) begin errors++; $display("FAIL rmid_data[%0d] got %02h need %02h", k, c_data[k], e.data); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_extremes();
    test_backpressure();
    test_pointer();
    test_ena_pause();
    test_reset_mid();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d entries need 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
